// File: rtl/cic_decim_prog_if.sv
// ---------------------------------------------------------------------------
// cic_decim_prog_if
// Sample and configuration bus for the programmable CIC decimator.
//
// Signals (directions as seen from the decimator, i.e. the slave modport):
//   data_i       in   DATAIN_WIDTH   signed input sample
//   valid_i      in   1              data_i valid this cycle
//   rate_i       in   RATE_WIDTH     requested decimation ratio R
//   shift_i      in   SHIFT_WIDTH    output right-shift (normalisation)
//   rate_load_i  in   1              pulse: capture rate_i/shift_i as pending
//   data_o       out  DATAOUT_WIDTH  signed decimated output
//   valid_o      out  1              data_o valid for one enabled cycle
//   ovf_o        out  1              saturation on this output, with valid_o
//
// The master modport is the producer/consumer side (source + sink).
// ---------------------------------------------------------------------------
interface cic_decim_prog_if #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 16,
    parameter int RATE_WIDTH    = 7,
    parameter int SHIFT_WIDTH   = 6
);
    logic signed [DATAIN_WIDTH-1:0]  data_i;
    logic                            valid_i;
    logic        [RATE_WIDTH-1:0]    rate_i;
    logic        [SHIFT_WIDTH-1:0]   shift_i;
    logic                            rate_load_i;
    logic signed [DATAOUT_WIDTH-1:0] data_o;
    logic                            valid_o;
    logic                            ovf_o;

    modport master (
        output data_i, valid_i, rate_i, shift_i, rate_load_i,
        input  data_o, valid_o, ovf_o
    );

    modport slave (
        input  data_i, valid_i, rate_i, shift_i, rate_load_i,
        output data_o, valid_o, ovf_o
    );
endinterface

// File: rtl/cic_decim_prog.sv
// ---------------------------------------------------------------------------
// cic_decim_prog
// Runtime-programmable CIC decimator: N pipelined integrators running at the
// input rate, an internal decimation counter, N comb stages (differential
// delay M) running at the output rate, and a rounding/saturating output stage
// with a programmable normalisation shift.
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset
//   en_i    in   global clock enable; low freezes every register
//   bus     slave modport of cic_decim_prog_if (samples, config, outputs)
// ---------------------------------------------------------------------------
module cic_decim_prog #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 16,
    parameter int M             = 2,
    parameter int N             = 5,
    parameter int MAXRATE       = 64,
    parameter int BITGROWTH     = 35,
    parameter int RATE_WIDTH    = 7,
    parameter int SHIFT_WIDTH   = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    cic_decim_prog_if.slave   bus
);
    localparam int ACC_W = DATAIN_WIDTH + BITGROWTH;

    // Saturation bounds expressed at the rounding width (ACC_W+1 bits).
    localparam logic signed [ACC_W:0] MAX_OUT =
        {{(ACC_W+2-DATAOUT_WIDTH){1'b0}}, {(DATAOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_OUT =
        {{(ACC_W+2-DATAOUT_WIDTH){1'b1}}, {(DATAOUT_WIDTH-1){1'b0}}};

    typedef logic signed [ACC_W-1:0] acc_t;

    // Ratios 0 and 1 both mean "every sample passes"; larger than MAXRATE is capped.
    function automatic logic [RATE_WIDTH-1:0] clampRate(input logic [RATE_WIDTH-1:0] r);
        logic [RATE_WIDTH-1:0] v;
        if (r <= RATE_WIDTH'(1))
            v = RATE_WIDTH'(1);
        else if (r > RATE_WIDTH'(MAXRATE))
            v = RATE_WIDTH'(MAXRATE);
        else
            v = r;
        return v;
    endfunction

    acc_t                    r_integ [N];
    logic [RATE_WIDTH-1:0]   r_cnt;
    logic [RATE_WIDTH-1:0]   r_rateAct;
    logic [SHIFT_WIDTH-1:0]  r_shiftAct;
    logic [RATE_WIDTH-1:0]   r_pendRate;
    logic [SHIFT_WIDTH-1:0]  r_pendShift;
    logic                    r_pend;
    logic                    r_strobe;
    logic [SHIFT_WIDTH-1:0]  r_strobeShift;
    acc_t                    r_sampler;
    logic                    r_sampValid;
    logic [SHIFT_WIDTH-1:0]  r_sampShift;
    acc_t                    r_combDly [N][M];
    acc_t                    r_comb [N];
    logic [N-1:0]            r_combValid;
    logic [SHIFT_WIDTH-1:0]  r_combShift [N];
    logic signed [DATAOUT_WIDTH-1:0] r_dataOut;
    logic                    r_outValid;
    logic                    r_ovf;

    logic                    w_accept;
    logic                    w_wrap;
    acc_t                    w_dataExt;
    acc_t                    w_combIn [N];
    logic [N-1:0]            w_combInValid;
    logic [SHIFT_WIDTH-1:0]  w_combInShift [N];
    logic signed [ACC_W:0]   w_wide;
    logic signed [ACC_W:0]   w_round;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W:0]   w_y;
    logic signed [DATAOUT_WIDTH-1:0] w_dataSat;
    logic                    w_ovf;

    assign w_accept  = en_i & bus.valid_i;
    assign w_wrap    = w_accept && (r_cnt == r_rateAct - RATE_WIDTH'(1));
    assign w_dataExt = {{(ACC_W-DATAIN_WIDTH){bus.data_i[DATAIN_WIDTH-1]}}, bus.data_i};

    // Integrators are pipelined: each stage adds the previous stage's old
    // value, so the cascade carries an (N-1)-sample latency but no long
    // carry chain through all stages. Wrap-around is intentional.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++)
                r_integ[i] <= '0;
        end else if (w_accept) begin
            r_integ[0] <= r_integ[0] + w_dataExt;
            for (int i = 1; i < N; i++)
                r_integ[i] <= r_integ[i] + r_integ[i-1];
        end
    end

    // Decimation counter and configuration. A reload is held pending until
    // the next wrap so the running period always finishes with the old ratio;
    // a load landing exactly on a wrap takes effect at that wrap. The strobe
    // carries the shift that was active during the period it closes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt         <= '0;
            r_rateAct     <= clampRate(bus.rate_i);
            r_shiftAct    <= bus.shift_i;
            r_pendRate    <= RATE_WIDTH'(1);
            r_pendShift   <= '0;
            r_pend        <= 1'b0;
            r_strobe      <= 1'b0;
            r_strobeShift <= '0;
        end else if (en_i) begin
            r_strobe <= w_wrap;
            if (w_wrap)
                r_strobeShift <= r_shiftAct;
            if (w_accept)
                r_cnt <= w_wrap ? '0 : r_cnt + RATE_WIDTH'(1);
            if (w_wrap) begin
                if (bus.rate_load_i) begin
                    r_rateAct  <= clampRate(bus.rate_i);
                    r_shiftAct <= bus.shift_i;
                end else if (r_pend) begin
                    r_rateAct  <= r_pendRate;
                    r_shiftAct <= r_pendShift;
                end
                r_pend <= 1'b0;
            end else if (bus.rate_load_i) begin
                r_pendRate  <= clampRate(bus.rate_i);
                r_pendShift <= bus.shift_i;
                r_pend      <= 1'b1;
            end
        end
    end

    // Sampler grabs the last integrator one cycle after the wrap, before any
    // later sample can modify it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sampler   <= '0;
            r_sampValid <= 1'b0;
            r_sampShift <= '0;
        end else if (en_i) begin
            r_sampValid <= r_strobe;
            if (r_strobe) begin
                r_sampler   <= r_integ[N-1];
                r_sampShift <= r_strobeShift;
            end
        end
    end

    // Input of each comb stage: the sampler for the first, the previous
    // comb stage for the rest.
    always_comb begin
        w_combIn[0]      = r_sampler;
        w_combInValid[0] = r_sampValid;
        w_combInShift[0] = r_sampShift;
        for (int k = 1; k < N; k++) begin
            w_combIn[k]      = r_comb[k-1];
            w_combInValid[k] = r_combValid[k-1];
            w_combInShift[k] = r_combShift[k-1];
        end
    end

    // Comb stages run at the output rate: both the difference register and
    // its M-deep delay line advance only when a decimated sample arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_combValid <= '0;
            for (int k = 0; k < N; k++) begin
                r_comb[k]      <= '0;
                r_combShift[k] <= '0;
                for (int j = 0; j < M; j++)
                    r_combDly[k][j] <= '0;
            end
        end else if (en_i) begin
            r_combValid <= w_combInValid;
            for (int k = 0; k < N; k++) begin
                if (w_combInValid[k]) begin
                    r_comb[k]       <= w_combIn[k] - r_combDly[k][M-1];
                    r_combShift[k]  <= w_combInShift[k];
                    r_combDly[k][0] <= w_combIn[k];
                    for (int j = 1; j < M; j++)
                        r_combDly[k][j] <= r_combDly[k][j-1];
                end
            end
        end
    end

    // Round half up, then saturate. One extra bit of headroom keeps the
    // rounding add from overflowing; the rounding constant is 2^(s-1), which
    // collapses to zero when s is zero.
    always_comb begin
        w_wide    = {r_comb[N-1][ACC_W-1], r_comb[N-1]};
        w_round   = ({{ACC_W{1'b0}}, 1'b1} << r_combShift[N-1]) >> 1;
        w_sum     = w_wide + w_round;
        w_y       = w_sum >>> r_combShift[N-1];
        w_dataSat = w_y[DATAOUT_WIDTH-1:0];
        w_ovf     = 1'b0;
        if (w_y > MAX_OUT) begin
            w_dataSat = MAX_OUT[DATAOUT_WIDTH-1:0];
            w_ovf     = 1'b1;
        end else if (w_y < MIN_OUT) begin
            w_dataSat = MIN_OUT[DATAOUT_WIDTH-1:0];
            w_ovf     = 1'b1;
        end
    end

    // Output register; data and flag hold between outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dataOut  <= '0;
            r_outValid <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (en_i) begin
            r_outValid <= r_combValid[N-1];
            if (r_combValid[N-1]) begin
                r_dataOut <= w_dataSat;
                r_ovf     <= w_ovf;
            end
        end
    end

    // Gating with en_i means a frozen cycle never presents the output, so
    // each output is seen for exactly one enabled cycle.
    assign bus.data_o  = r_dataOut;
    assign bus.valid_o = r_outValid & en_i;
    assign bus.ovf_o   = r_ovf;

endmodule
